// File: rtl/branch_resolve_unit.sv
// EX-stage branch/jump resolver: registered fetch redirect, pipeline flushes, link address, redirect counter.
// Optional build macro BRU_DELAY_SLOT_EN selects MIPS delay-slot semantics (Kill_EX tied low, link = PC+8).
module branch_resolve_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EX_Valid,
  input  logic             Stall,
  input  logic [29:0]      EX_PC,
  input  logic [3:0]       EX_Br_Type,
  input  logic [15:0]      EX_Imm16,
  input  logic [25:0]      EX_Index,
  input  logic [31:0]      EX_Rs_Data,
  input  logic [31:0]      EX_Rt_Data,
  output logic             PC_Src,
  output logic [29:0]      Target_PC_Addr,
  output logic             Flush_IF_ID,
  output logic             Flush_ID_EX,
  output logic             Kill_EX,
  output logic [31:0]      Link_Addr,
  output logic [CNT_W-1:0] Redirect_Cnt
);

  typedef enum logic {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } state_t;

  localparam logic [3:0] BR_BEQ  = 4'd1;
  localparam logic [3:0] BR_BNE  = 4'd2;
  localparam logic [3:0] BR_BLEZ = 4'd3;
  localparam logic [3:0] BR_BGTZ = 4'd4;
  localparam logic [3:0] BR_BLTZ = 4'd5;
  localparam logic [3:0] BR_BGEZ = 4'd6;
  localparam logic [3:0] BR_J    = 4'd7;
  localparam logic [3:0] BR_JAL  = 4'd8;
  localparam logic [3:0] BR_JR   = 4'd9;
  localparam logic [3:0] BR_JALR = 4'd10;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic             r_pc_src;
  logic             r_flush;
  logic [29:0]      r_target;
  logic [CNT_W-1:0] r_cnt;

  logic        w_rs_zero;
  logic        w_rs_neg;
  logic        w_taken;
  logic        w_accept;
  logic [29:0] w_pc_plus1;
  logic [29:0] w_br_target;
  logic [29:0] w_j_target;
  logic [29:0] w_jr_target;
  logic [29:0] w_target;
  logic [29:0] w_link_word;

  assign w_rs_zero   = (EX_Rs_Data == 32'd0);
  assign w_rs_neg    = EX_Rs_Data[31];
  assign w_pc_plus1  = EX_PC + 30'd1;
  assign w_br_target = w_pc_plus1 + {{14{EX_Imm16[15]}}, EX_Imm16};
  assign w_j_target  = {w_pc_plus1[29:26], EX_Index};
  assign w_jr_target = EX_Rs_Data[31:2];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_taken  = 1'b0;
    w_target = w_br_target;
    case (EX_Br_Type)
      BR_BEQ:         w_taken = (EX_Rs_Data == EX_Rt_Data);
      BR_BNE:         w_taken = (EX_Rs_Data != EX_Rt_Data);
      BR_BLEZ:        w_taken = w_rs_neg | w_rs_zero;
      BR_BGTZ:        w_taken = ~w_rs_neg & ~w_rs_zero;
      BR_BLTZ:        w_taken = w_rs_neg;
      BR_BGEZ:        w_taken = ~w_rs_neg;
      BR_J, BR_JAL: begin
        w_taken  = 1'b1;
        w_target = w_j_target;
      end
      BR_JR, BR_JALR: begin
        w_taken  = 1'b1;
        w_target = w_jr_target;
      end
      default:        w_taken = 1'b0;
    endcase
  end

  // Delay-slot or wrong-path instructions in EX are ignored while redirecting.
  assign w_accept = EX_Valid & ~Stall & w_taken & (r_state == IDLE);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_pc_src <= 1'b0;
      r_flush  <= 1'b0;
      r_target <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state  <= REDIRECT;
            r_pc_src <= 1'b1;
            r_flush  <= 1'b1;
            r_target <= w_target;
            if (r_cnt != '1) r_cnt <= r_cnt + CNT_ONE;
          end
        end
        REDIRECT: begin
          if (!Stall) begin
            r_state  <= IDLE;
            r_pc_src <= 1'b0;
            r_flush  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign PC_Src         = r_pc_src;
  assign Target_PC_Addr = r_target;
  assign Flush_IF_ID    = r_flush;
  assign Flush_ID_EX    = r_flush;
  assign Redirect_Cnt   = r_cnt;

`ifdef BRU_DELAY_SLOT_EN
  assign Kill_EX     = 1'b0;
  assign w_link_word = EX_PC + 30'd2;
`else
  assign Kill_EX     = r_pc_src;
  assign w_link_word = w_pc_plus1;
`endif

  assign Link_Addr = {w_link_word, 2'b00};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed vector table, multi-cycle sequences, random run vs reference model.
// Counter width is reduced so saturation is reachable in a short run; expectations follow BRU_DELAY_SLOT_EN.
module tb_branch_resolve_unit;

  localparam int TB_CNT_W = 5;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;
`ifdef BRU_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                ex_valid = 1'b0;
  logic                stall = 1'b0;
  logic [29:0]         ex_pc = '0;
  logic [3:0]          ex_br_type = '0;
  logic [15:0]         ex_imm16 = '0;
  logic [25:0]         ex_index = '0;
  logic [31:0]         ex_rs = '0;
  logic [31:0]         ex_rt = '0;
  logic                pc_src;
  logic [29:0]         target_pc_addr;
  logic                flush_if_id;
  logic                flush_id_ex;
  logic                kill_ex;
  logic [31:0]         link_addr;
  logic [TB_CNT_W-1:0] redirect_cnt;

  branch_resolve_unit #(.CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst(rst),
    .EX_Valid(ex_valid), .Stall(stall), .EX_PC(ex_pc), .EX_Br_Type(ex_br_type),
    .EX_Imm16(ex_imm16), .EX_Index(ex_index), .EX_Rs_Data(ex_rs), .EX_Rt_Data(ex_rt),
    .PC_Src(pc_src), .Target_PC_Addr(target_pc_addr), .Flush_IF_ID(flush_if_id),
    .Flush_ID_EX(flush_id_ex), .Kill_EX(kill_ex), .Link_Addr(link_addr),
    .Redirect_Cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: redirect pending flag, latched target, redirect count.
  bit          m_redir = 1'b0;
  logic [29:0] m_target = '0;
  int          m_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit ref_taken(input int t, input logic [31:0] rs, input logic [31:0] rt);
    int s;
    s = $signed(rs);
    case (t)
      1: return rs == rt;
      2: return rs != rt;
      3: return s <= 0;
      4: return s > 0;
      5: return s < 0;
      6: return s >= 0;
      7, 8, 9, 10: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [29:0] ref_target(input int t, input logic [29:0] pc, input logic [15:0] imm,
                                             input logic [25:0] idx, input logic [31:0] rs);
    longint nxt;
    longint region;
    nxt = longint'(pc) + 1;
    if (t == 7 || t == 8) begin
      region = (nxt >> 26) & 15;
      return 30'((region << 26) | longint'(idx));
    end
    if (t == 9 || t == 10) return 30'(longint'(rs) / 4);
    return 30'((nxt + longint'($signed(imm))) & 64'h3FFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_link(input logic [29:0] pc);
    longint w;
    w = (longint'(pc) + (DS ? 2 : 1)) & 64'h3FFF_FFFF;
    return 32'(w * 4);
  endfunction

  task automatic drive(input bit v, input bit s, input int t, input logic [29:0] pc, input logic [15:0] imm,
                       input logic [25:0] idx, input logic [31:0] rs, input logic [31:0] rt);
    ex_valid = v; stall = s; ex_br_type = 4'(t); ex_pc = pc;
    ex_imm16 = imm; ex_index = idx; ex_rs = rs; ex_rt = rt;
  endtask

  task automatic compare_all();
    check("pc_src", 32'(pc_src), 32'(m_redir));
    check("target", 32'(target_pc_addr), 32'(m_target));
    check("flush_if_id", 32'(flush_if_id), 32'(m_redir));
    check("flush_id_ex", 32'(flush_id_ex), 32'(m_redir));
    check("kill_ex", 32'(kill_ex), DS ? 32'd0 : 32'(m_redir));
    check("redirect_cnt", 32'(redirect_cnt), 32'(m_cnt));
  endtask

  // Advance one clock: model consumes the inputs present at the edge, then outputs are compared.
  task automatic tick();
    if (!rst) begin
      if (!m_redir) begin
        if (ex_valid && !stall && ref_taken(int'(ex_br_type), ex_rs, ex_rt)) begin
          m_redir  = 1'b1;
          m_target = ref_target(int'(ex_br_type), ex_pc, ex_imm16, ex_index, ex_rs);
          if (m_cnt < CNT_MAX) m_cnt++;
        end
      end else if (!stall) begin
        m_redir = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic model_reset();
    m_redir = 1'b0; m_target = '0; m_cnt = 0;
  endtask

  typedef struct {
    int          br_type;
    logic [29:0] pc;
    logic [15:0] imm;
    logic [25:0] idx;
    logic [31:0] rs;
    logic [31:0] rt;
    bit          exp_taken;
    logic [29:0] exp_target;
    logic [31:0] exp_link_nods;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{1,  30'h0000C00, 16'h0004, 26'h0,       32'd5,        32'd5, 1'b1, 30'h0000C05, 32'h3004});
    vecs.push_back('{2,  30'h0000C00, 16'h0004, 26'h0,       32'd5,        32'd5, 1'b0, 30'h0,       32'h3004});
    vecs.push_back('{7,  30'h0000C00, 16'h0000, 26'h100,     32'd0,        32'd0, 1'b1, 30'h0000100, 32'h3004});
    vecs.push_back('{8,  30'h0000C00, 16'h0000, 26'h100,     32'd0,        32'd0, 1'b1, 30'h0000100, 32'h3004});
    vecs.push_back('{9,  30'h0000C00, 16'h0000, 26'h0,       32'h00401003, 32'd0, 1'b1, 30'h0100400, 32'h3004});
    vecs.push_back('{3,  30'h0000C00, 16'hFFFF, 26'h0,       32'h80000000, 32'd0, 1'b1, 30'h0000C00, 32'h3004});
    vecs.push_back('{4,  30'h0000C00, 16'h0004, 26'h0,       32'd0,        32'd0, 1'b0, 30'h0,       32'h3004});
    vecs.push_back('{1,  30'h3FFFFFFF, 16'h0000, 26'h0,      32'd7,        32'd7, 1'b1, 30'h0000000, 32'h0});
    vecs.push_back('{5,  30'h0000C00, 16'h0010, 26'h0,       32'd1,        32'd0, 1'b0, 30'h0,       32'h3004});
    vecs.push_back('{6,  30'h0000C00, 16'h0010, 26'h0,       32'd0,        32'd0, 1'b1, 30'h0000C11, 32'h3004});
    vecs.push_back('{10, 30'h0000C00, 16'h0000, 26'h0,       32'h00003008, 32'd0, 1'b1, 30'h0000C02, 32'h3004});
    vecs.push_back('{13, 30'h0000C00, 16'h0004, 26'h0,       32'd5,        32'd5, 1'b0, 30'h0,       32'h3004});
    vecs.push_back('{2,  30'h0000C00, 16'h8000, 26'h0,       32'd1,        32'd2, 1'b1, 30'h3FFF8C01, 32'h3004});
    vecs.push_back('{7,  30'h3C000000, 16'h0000, 26'h3FFFFFF, 32'd0,       32'd0, 1'b1, 30'h3FFFFFFF, 32'hF0000004});
  end

  initial begin
    logic [29:0] held_target;
    int          held_cnt;

    // Reset held: every output at its reset value, even across edges.
    #1;
    model_reset();
    compare_all();
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Directed vectors: one cycle valid, then one idle cycle to return to IDLE.
    foreach (vecs[i]) begin
      drive(1, 0, vecs[i].br_type, vecs[i].pc, vecs[i].imm, vecs[i].idx, vecs[i].rs, vecs[i].rt);
      #1;
      check($sformatf("vec%0d_link", i), link_addr,
            DS ? vecs[i].exp_link_nods + 32'd4 : vecs[i].exp_link_nods);
      held_target = target_pc_addr;
      tick();
      check($sformatf("vec%0d_taken", i), 32'(pc_src), 32'(vecs[i].exp_taken));
      check($sformatf("vec%0d_target", i), 32'(target_pc_addr),
            32'(vecs[i].exp_taken ? vecs[i].exp_target : held_target));
      drive(0, 0, 0, '0, '0, '0, '0, '0);
      tick();
      check($sformatf("vec%0d_idle", i), 32'(pc_src), 32'd0);
    end

    // Taken branch held off by a 2-cycle stall is resolved only after release.
    held_cnt = int'(redirect_cnt);
    drive(1, 1, 1, 30'h0000C00, 16'h0004, '0, 32'd9, 32'd9);
    tick();
    check("stall_hold1", 32'(pc_src), 32'd0);
    tick();
    check("stall_hold2", 32'(pc_src), 32'd0);
    stall = 1'b0;
    tick();
    check("stall_release", 32'(pc_src), 32'd1);
    // 3-cycle stall during REDIRECT keeps PC_Src high; a single count.
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("redir_stall%0d", k), 32'(pc_src), 32'd1);
    end
    drive(0, 0, 0, '0, '0, '0, '0, '0);
    tick();
    check("redir_stall_exit", 32'(pc_src), 32'd0);
    check("redir_stall_cnt", 32'(redirect_cnt), 32'(held_cnt + 1));

    // Branch in the EX slot during REDIRECT is ignored.
    drive(1, 0, 7, 30'h0000C00, '0, 26'h200, '0, '0);
    tick();
    drive(1, 0, 7, 30'h0000C00, '0, 26'h300, '0, '0);
    tick();
    check("b2b_ignored_pc_src", 32'(pc_src), 32'd0);
    check("b2b_ignored_target", 32'(target_pc_addr), 32'h200);
    drive(0, 0, 0, '0, '0, '0, '0, '0);
    tick();

    // Asynchronous reset mid-REDIRECT clears outputs without an edge.
    drive(1, 1, 0, '0, '0, '0, '0, '0);
    drive(1, 0, 8, 30'h0000C00, '0, 26'h155, '0, '0);
    tick();
    stall = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_pc_src", 32'(pc_src), 32'd0);
    compare_all();
    drive(0, 0, 0, '0, '0, '0, '0, '0);
    tick();
    rst = 1'b0;
    tick();

    // Randomized run against the reference model.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] rs_v;
      logic [31:0] rt_v;
      case ($urandom_range(0, 3))
        0: rs_v = 32'd0;
        1: rs_v = 32'h80000000;
        2: rs_v = 32'd5;
        default: rs_v = $urandom;
      endcase
      rt_v = ($urandom_range(0, 1) == 0) ? rs_v : $urandom;
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, int'($urandom_range(0, 15)),
            30'($urandom), 16'($urandom), 26'($urandom), rs_v, rt_v);
      #1;
      check("rand_link", link_addr, ref_link(ex_pc));
      tick();
    end

    // Saturation: far more redirects than the counter can hold.
    for (int n = 0; n < CNT_MAX + 8; n++) begin
      drive(1, 0, 7, 30'h0000C00, '0, 26'(n), '0, '0);
      tick();
      drive(0, 0, 0, '0, '0, '0, '0, '0);
      tick();
    end
    check("cnt_saturated", 32'(redirect_cnt), 32'(CNT_MAX));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
